// File: rtl/tdm_pkg.sv
// Shared types for the 4-channel TDM demultiplexer.
// Optional frame buffering is selected in the top with TDM_DEMUX4_FRAME_BUF_EN.
package tdm_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } sync_state_t;

    // Slot counter is exactly NUM_CH wide in range, so natural wrap gives 3 -> 0.
    function automatic slot_t slot_inc(input slot_t s);
        return s + slot_t'(1);
    endfunction

endpackage

// File: rtl/tdm_slot_tracker.sv
// Frame alignment tracker: hunt/locked FSM, slot counter and sticky sync error.
// Produces a combinational write strobe/slot for the data path in the same cycle.
module tdm_slot_tracker
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  din_valid,
    input  logic  frame_sync,
    input  logic  err_clr,
    output logic  wr_en,
    output slot_t wr_slot,
    output logic  sync_err,
    output logic  locked
);

    sync_state_t r_state;
    slot_t       r_slot;
    logic        r_err;

    sync_state_t w_state_nxt;
    slot_t       w_slot_nxt;
    logic        w_err_new;

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_err_new   = 1'b0;
        wr_en       = 1'b0;
        wr_slot     = r_slot;
        if (din_valid) begin
            case (r_state)
                HUNT: begin
                    if (frame_sync) begin
                        wr_en       = 1'b1;
                        wr_slot     = '0;
                        w_slot_nxt  = slot_t'(1);
                        w_state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // Early sync realigns onto the marker; on-time sync is a normal start.
                        w_err_new  = (r_slot != '0);
                        wr_en      = 1'b1;
                        wr_slot    = '0;
                        w_slot_nxt = slot_t'(1);
                    end else if (r_slot != '0) begin
                        wr_en      = 1'b1;
                        wr_slot    = r_slot;
                        w_slot_nxt = slot_inc(r_slot);
                    end else begin
                        w_err_new   = 1'b1;
                        w_slot_nxt  = '0;
                        w_state_nxt = HUNT;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_slot_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
            r_slot  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            // A fresh error outranks a simultaneous clear.
            if (w_err_new)
                r_err <= 1'b1;
            else if (err_clr)
                r_err <= 1'b0;
        end
    end

    assign sync_err = r_err;
    assign locked   = (r_state == LOCKED);

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer data path: slot-addressed channel registers.
// Define TDM_DEMUX4_FRAME_BUF_EN to publish whole frames at once via shadow registers.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        din,
    input  logic                    din_valid,
    input  logic                    frame_sync,
    input  logic                    err_clr,
    output logic [NUM_CH*WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]       ch_valid,
    output logic                    frame_done,
    output logic                    sync_err,
    output logic                    locked
);

    logic                         w_wr_en;
    slot_t                        w_wr_slot;
    logic [NUM_CH-1:0]            w_sel;
    logic                         w_commit;

    logic [NUM_CH-1:0][WIDTH-1:0] r_ch;
    logic [NUM_CH-1:0]            r_ch_valid;
    logic                         r_frame_done;

    tdm_slot_tracker u_trk (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .err_clr    (err_clr),
        .wr_en      (w_wr_en),
        .wr_slot    (w_wr_slot),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_sel
        assign w_sel[k] = w_wr_en && (w_wr_slot == slot_t'(k));
    end

    // Writing the last slot always closes an unbroken 0..3 run: any realignment resets to slot 1.
    assign w_commit = w_sel[NUM_CH-1];

`ifdef TDM_DEMUX4_FRAME_BUF_EN
    logic [NUM_CH-2:0][WIDTH-1:0] r_shadow;
    logic [NUM_CH-1:0][WIDTH-1:0] w_frame;
    logic                         w_discard;

    // A valid sample that writes nothing while locked is a missing-sync drop.
    assign w_discard = din_valid && locked && !w_wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (w_discard) begin
            r_shadow <= '0;
        end else begin
            for (int k = 0; k < NUM_CH-1; k++)
                if (w_sel[k])
                    r_shadow[k] <= din;
        end
    end

    always_comb begin
        w_frame           = '0;
        w_frame[NUM_CH-1] = din;
        for (int k = 0; k < NUM_CH-1; k++)
            w_frame[k] = r_shadow[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch         <= '0;
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_ch_valid   <= {NUM_CH{w_commit}};
            r_frame_done <= w_commit;
            if (w_commit)
                r_ch <= w_frame;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch         <= '0;
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_ch_valid   <= w_sel;
            r_frame_done <= w_commit;
            for (int k = 0; k < NUM_CH; k++)
                if (w_sel[k])
                    r_ch[k] <= din;
        end
    end
`endif

    assign ch_data    = r_ch;
    assign ch_valid   = r_ch_valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 with a slot-level reference model.
// Honors TDM_DEMUX4_FRAME_BUF_EN to select the buffered expectations.
module tb_tdm_demux4;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic         err_clr = 1'b0;
    logic [4*W-1:0] ch_data;
    logic [3:0]   ch_valid;
    logic         frame_done;
    logic         sync_err;
    logic         locked;

    int n_chk = 0;
    int n_fail = 0;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .err_clr    (err_clr),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    // Reference model: expected outputs after each clock edge.
    logic [7:0] m_ch [4];
    logic [7:0] m_sh [4];
    logic [3:0] m_valid;
    bit         m_fd, m_err, m_locked;
    int         m_slot;

    function automatic logic [31:0] m_data();
        return {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_ch[i] = '0; m_sh[i] = '0; end
        m_valid = '0; m_fd = 0; m_err = 0; m_locked = 0; m_slot = 0;
    endtask

    task automatic model_write(input int k, input logic [7:0] d);
`ifdef TDM_DEMUX4_FRAME_BUF_EN
        m_sh[k] = d;
        if (k == 3) begin
            for (int i = 0; i < 4; i++) m_ch[i] = m_sh[i];
            m_valid = 4'hF;
            m_fd = 1;
        end
`else
        m_ch[k] = d;
        m_valid[k] = 1'b1;
        if (k == 3) m_fd = 1;
`endif
    endtask

    task automatic model_step(input bit v, input bit s, input logic [7:0] d, input bit c);
        bit err_new;
        err_new = 0;
        m_valid = '0;
        m_fd = 0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin model_write(0, d); m_slot = 1; m_locked = 1; end
            end else if (s) begin
                if (m_slot != 0) err_new = 1;
                model_write(0, d);
                m_slot = 1;
            end else if (m_slot != 0) begin
                model_write(m_slot, d);
                m_slot = (m_slot + 1) % 4;
            end else begin
                err_new = 1;
                m_locked = 0;
            end
        end
        if (err_new) m_err = 1;
        else if (c) m_err = 0;
    endtask

    // Drive one cycle of inputs, advance the model, and land at edge+1 for sampling.
    task automatic cycle(input bit v, input bit s, input logic [7:0] d, input bit c);
        din_valid = v; frame_sync = s; din = d; err_clr = c;
        @(posedge clk);
        #1;
        model_step(v, s, d, c);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        din_valid = 0; frame_sync = 0; din = '0; err_clr = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 1, 8'h11, 0);
        cycle(1, 0, 8'h22, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({ch_data, ch_valid, frame_done, sync_err, locked} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_frame got data=%h vld=%b fd=%b err=%b lk=%b exp all 0",
                     ch_data, ch_valid, frame_done, sync_err, locked);
        end
        model_reset();
        din_valid = 0; frame_sync = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 0, 8'h55, 0);
        n_chk++;
        if (ch_valid !== 4'b0 || ch_data !== '0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_nosync_ignored got vld=%b data=%h lk=%b exp 0/0/0", ch_valid, ch_data, locked);
        end
    endtask

    task automatic test_nominal();
        logic [7:0] vals [4];
        logic [3:0] exp_v;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            cycle(1, (i == 0), vals[i], 0);
`ifdef TDM_DEMUX4_FRAME_BUF_EN
            exp_v = (i == 3) ? 4'hF : 4'h0;
`else
            exp_v = 4'b0001 << i;
`endif
            n_chk++;
            if (ch_valid !== exp_v || frame_done !== (i == 3) || locked !== 1'b1) begin
                n_fail++;
                $display("FAIL nominal_slot%0d got vld=%b fd=%b lk=%b exp vld=%b fd=%b lk=1",
                         i, ch_valid, frame_done, locked, exp_v, (i == 3));
            end
        end
        n_chk++;
        if (ch_data !== 32'h44332211) begin
            n_fail++;
            $display("FAIL nominal_data got %h exp 44332211", ch_data);
        end
        cycle(0, 0, 8'h00, 0);
        n_chk++;
        if (ch_valid !== 4'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_pulse_width got vld=%b fd=%b exp 0/0", ch_valid, frame_done);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, (i == 0), vals[i], 0);
            n_chk++;
            if (ch_valid !== m_valid || frame_done !== m_fd || ch_data !== m_data()) begin
                n_fail++;
                $display("FAIL gaps_slot%0d got vld=%b fd=%b data=%h exp vld=%b fd=%b data=%h",
                         i, ch_valid, frame_done, ch_data, m_valid, m_fd, m_data());
            end
            for (int g = 0; g < 3; g++) begin
                cycle(0, 0, 8'hEE, 0);
                n_chk++;
                if (ch_valid !== 4'b0 || frame_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gaps_idle got vld=%b fd=%b exp 0/0", ch_valid, frame_done);
                end
            end
        end
        n_chk++;
        if (ch_data !== 32'h44332211 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_data got %h lk=%b exp 44332211 lk=1", ch_data, locked);
        end
    endtask

    task automatic test_early_sync();
        bit saw_fd;
        apply_reset();
        saw_fd = 0;
        cycle(1, 1, 8'h01, 0); saw_fd |= frame_done;
        cycle(1, 0, 8'h02, 0); saw_fd |= frame_done;
        cycle(1, 1, 8'hAA, 0); saw_fd |= frame_done;
        n_chk++;
        if (sync_err !== 1'b1 || locked !== 1'b1 || ch_data !== m_data()) begin
            n_fail++;
            $display("FAIL early_sync_flag got err=%b lk=%b data=%h exp err=1 lk=1 data=%h",
                     sync_err, locked, ch_data, m_data());
        end
`ifndef TDM_DEMUX4_FRAME_BUF_EN
        n_chk++;
        if (ch_data[7:0] !== 8'hAA || ch_valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL early_sync_ch0 got ch0=%h vld=%b exp AA 0001", ch_data[7:0], ch_valid);
        end
`endif
        cycle(1, 0, 8'h03, 0); saw_fd |= frame_done;
        n_chk++;
        if (ch_valid !== m_valid || saw_fd !== 1'b0) begin
            n_fail++;
            $display("FAIL early_sync_next got vld=%b fd_seen=%b exp vld=%b fd_seen=0", ch_valid, saw_fd, m_valid);
        end
        cycle(1, 0, 8'h04, 0);
        cycle(1, 0, 8'h05, 0);
        n_chk++;
        if (ch_data !== 32'h050403AA || frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL early_sync_realigned got data=%h fd=%b exp 050403AA fd=1", ch_data, frame_done);
        end
    endtask

    task automatic test_missing_sync();
        cycle(0, 0, 8'h00, 1);
        n_chk++;
        if (sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_alone got err=%b exp 0", sync_err);
        end
        cycle(1, 0, 8'hBB, 0);
        n_chk++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || ch_data !== 32'h050403AA || ch_valid !== 4'b0) begin
            n_fail++;
            $display("FAIL missing_sync got err=%b lk=%b data=%h vld=%b exp 1/0/050403AA/0000",
                     sync_err, locked, ch_data, ch_valid);
        end
    endtask

    task automatic test_err_clr();
        cycle(0, 0, 8'h00, 1);
        n_chk++;
        if (sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL errclr_clear got err=%b exp 0", sync_err);
        end
        cycle(1, 1, 8'h10, 0);
        cycle(1, 0, 8'h20, 0);
        cycle(1, 1, 8'h30, 1);
        n_chk++;
        if (sync_err !== 1'b1) begin
            n_fail++;
            $display("FAIL errclr_collision got err=%b exp 1", sync_err);
        end
        cycle(0, 0, 8'h00, 0);
        n_chk++;
        if (sync_err !== 1'b1) begin
            n_fail++;
            $display("FAIL errclr_sticky got err=%b exp 1", sync_err);
        end
        cycle(0, 0, 8'h00, 1);
        n_chk++;
        if (sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL errclr_release got err=%b exp 0", sync_err);
        end
    endtask

    task automatic test_random();
        bit v, s, c;
        logic [7:0] d;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(99, 0) < 75);
            if (!m_locked)        s = ($urandom_range(99, 0) < 30);
            else if (m_slot == 0) s = ($urandom_range(99, 0) < 90);
            else                  s = ($urandom_range(99, 0) < 5);
            c = ($urandom_range(99, 0) < 5);
            d = 8'($urandom);
            cycle(v, s, d, c);
            n_chk++;
            if ({ch_data, ch_valid, frame_done, sync_err, locked} !==
                {m_data(), m_valid, m_fd, m_err, m_locked}) begin
                n_fail++;
                $display("FAIL random_c%0d got data=%h vld=%b fd=%b err=%b lk=%b exp data=%h vld=%b fd=%b err=%b lk=%b",
                         i, ch_data, ch_valid, frame_done, sync_err, locked,
                         m_data(), m_valid, m_fd, m_err, m_locked);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_early_sync();
        test_missing_sync();
        test_err_clr();
        test_gaps();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
